// File: rtl/display_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// display_scan : time-multiplexed 7-segment driver with double-buffered data,
//                anti-ghost blanking, DP, per-digit blank, leading-zero blank. Rev 1.0
// ----------------------------------------------------------------------------
module display_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit DIG_ACT_LOW  = 1'b1,
  parameter bit LZ_BLANK     = 1'b0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [4*NUM_DIGITS-1:0] DisVal,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic [NUM_DIGITS-1:0]   BlankIn,
  input  logic                    Load,
  output logic [7:0]              SegOut,
  output logic [NUM_DIGITS-1:0]   DigSel,
  output logic                    FrameDone
);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam int PMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0]         SHOW_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]         BLANK_LAST = PW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF    = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF    = DIG_ACT_LOW ? '1 : '0;

  state_t                  state, state_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [PW-1:0]           presc, presc_nx;
  logic                    frame_start, done_nx, fresh, take;
  logic [4*NUM_DIGITS-1:0] pend_val, act_val, val_nx;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp, dp_nx;
  logic [NUM_DIGITS-1:0]   pend_blank, act_blank, blank_nx;
  logic [NUM_DIGITS-1:0]   lz_dark, dig_hot, dig_nx;
  logic                    zero_run;
  logic [3:0]              nib;
  logic [7:0]              seg_low, seg_nx;

  // Active-low pattern {dp,g,f,e,d,c,b,a} with dp off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_BLANK;
      idx   <= '0;
      presc <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      presc <= presc_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    presc_nx    = presc + 1'b1;
    done_nx     = 1'b0;
    frame_start = 1'b0;
    case (state)
      ST_BLANK: begin
        if (presc == BLANK_LAST) begin
          state_nx = ST_SHOW;
          presc_nx = '0;
        end
      end
      ST_SHOW: begin
        if (presc == SHOW_LAST) begin
          if (BLANK_CYCLES > 0) state_nx = ST_BLANK;
          else                  state_nx = ST_SHOW;
          presc_nx    = '0;
          idx_nx      = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          done_nx     = (idx == IDX_LAST);
          frame_start = (idx == IDX_LAST);
        end
      end
      default: begin
        state_nx = ST_BLANK;
        presc_nx = '0;
      end
    endcase
  end

  // The first edge out of reset also opens a frame, so a Load there is shown at once.
  always_comb begin
    take     = frame_start | fresh;
    val_nx   = act_val;
    dp_nx    = act_dp;
    blank_nx = act_blank;
    if (take) begin
      val_nx   = Load ? DisVal  : pend_val;
      dp_nx    = Load ? DpIn    : pend_dp;
      blank_nx = Load ? BlankIn : pend_blank;
    end

    zero_run = 1'b1;
    lz_dark  = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (val_nx[4*k +: 4] == 4'h0);
      lz_dark[k] = zero_run;
    end

    nib     = val_nx[{idx_nx, 2'b00} +: 4];
    seg_low = 8'hFF;
    if (!blank_nx[idx_nx]) begin
      if (!(LZ_BLANK && lz_dark[idx_nx])) seg_low = hex_to_seg(nib);
      if (dp_nx[idx_nx]) seg_low[7] = 1'b0;
    end

    dig_hot         = '0;
    dig_hot[idx_nx] = 1'b1;
    if (state_nx == ST_SHOW) begin
      seg_nx = SEG_ACT_LOW ? seg_low : ~seg_low;
      dig_nx = DIG_ACT_LOW ? ~dig_hot : dig_hot;
    end else begin
      seg_nx = SEG_OFF;
      dig_nx = DIG_OFF;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fresh      <= 1'b1;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      SegOut     <= SEG_OFF;
      DigSel     <= DIG_OFF;
      FrameDone  <= 1'b0;
    end else begin
      fresh <= 1'b0;
      if (Load) begin
        pend_val   <= DisVal;
        pend_dp    <= DpIn;
        pend_blank <= BlankIn;
      end
      act_val   <= val_nx;
      act_dp    <= dp_nx;
      act_blank <= blank_nx;
      SegOut    <= seg_nx;
      DigSel    <= dig_nx;
      FrameDone <= done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// tb_display_scan: two configurations driven in parallel, checked cycle by cycle
// against a frame-timing reference model through a scoreboard queue.
module tb_display_scan;

  localparam int N = 4;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       fd;
  } out_t;

  typedef struct packed {
    out_t a;
    out_t b;
  } exp_t;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] dis_val = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;
  logic        fd_a, fd_b;

  always #5 clk = ~clk;

  display_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
                 .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1), .LZ_BLANK(1'b1)) dut_a (
    .Clk(clk), .Rst(rst), .DisVal(dis_val), .DpIn(dp_in), .BlankIn(blank_in),
    .Load(load), .SegOut(seg_a), .DigSel(dig_a), .FrameDone(fd_a));

  display_scan #(.NUM_DIGITS(4), .REFRESH_DIV(3), .BLANK_CYCLES(0),
                 .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0), .LZ_BLANK(1'b0)) dut_b (
    .Clk(clk), .Rst(rst), .DisVal(dis_val), .DpIn(dp_in), .BlankIn(blank_in),
    .Load(load), .SegOut(seg_b), .DigSel(dig_b), .FrameDone(fd_b));

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          t = 0;
  logic [15:0] pend_v;
  logic [3:0]  pend_dp, pend_bl;
  logic [15:0] cur_v [2];
  logic [3:0]  cur_dp [2];
  logic [3:0]  cur_bl [2];

  task automatic capture(input int id);
    cur_v[id]  = pend_v;
    cur_dp[id] = pend_dp;
    cur_bl[id] = pend_bl;
  endtask

  // Edge t after reset: first digit shows from t=lead; each later digit has bc blank
  // clocks then rd show clocks; frames are N*(bc+rd) long and latch new data at their start.
  task automatic predict(input int id, input int rd, input int bc, input bit seg_low,
                         input bit dig_low, input bit lz, output out_t o);
    int lead, s, fl, up, f, pos, d, ph;
    logic [7:0]  sv;
    logic [3:0]  hot;
    logic [15:0] v;
    lead  = (bc > 0) ? bc : 1;
    s     = bc + rd;
    fl    = N * s;
    o.seg = seg_low ? 8'hFF : 8'h00;
    o.dig = dig_low ? 4'hF : 4'h0;
    o.fd  = 1'b0;
    if (t == 1) capture(id);
    if (t >= lead) begin
      up  = t - lead + bc;
      f   = up / fl;
      pos = up % fl;
      if (pos == 0 && f >= 1) begin
        capture(id);
        o.fd = 1'b1;
      end
      d  = pos / s;
      ph = pos % s;
      if (ph >= bc) begin
        v = cur_v[id];
        if (cur_bl[id][d]) sv = 8'hFF;
        else begin
          sv = (lz && d > 0 && (v >> (4*d)) == 16'h0) ? 8'hFF : SEG_TAB[v[4*d +: 4]];
          if (cur_dp[id][d]) sv[7] = 1'b0;
        end
        o.seg = seg_low ? sv : ~sv;
        hot   = 4'b0001 << d;
        o.dig = dig_low ? ~hot : hot;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic ld, input logic [15:0] v,
                     input logic [3:0] dp, input logic [3:0] bl);
    exp_t e;
    @(negedge clk);
    rst = r; load = ld; dis_val = v; dp_in = dp; blank_in = bl;
    if (r) begin
      t = 0;
      pend_v = '0; pend_dp = '0; pend_bl = '0;
      for (int id = 0; id < 2; id++) begin
        cur_v[id] = '0; cur_dp[id] = '0; cur_bl[id] = '0;
      end
      e.a = '{seg: 8'hFF, dig: 4'hF, fd: 1'b0};
      e.b = '{seg: 8'h00, dig: 4'h0, fd: 1'b0};
    end else begin
      t++;
      if (ld) begin
        pend_v = v; pend_dp = dp; pend_bl = bl;
      end
      predict(0, 4, 1, 1'b1, 1'b1, 1'b1, e.a);
      predict(1, 3, 0, 1'b0, 1'b0, 1'b0, e.b);
    end
    sb_q.push_back(e);
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] r;
    for (int k = 0; k < 4; k++)
      r[4*k +: 4] = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(0, 15));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("a.SegOut",    seg_a,             e.a.seg);
        chk("a.DigSel",    8'(dig_a),         8'(e.a.dig));
        chk("a.FrameDone", 8'(fd_a),          8'(e.a.fd));
        chk("b.SegOut",    seg_b,             e.b.seg);
        chk("b.DigSel",    8'(dig_b),         8'(e.b.dig));
        chk("b.FrameDone", 8'(fd_b),          8'(e.b.fd));
      end
    end
  end

  initial begin
    int         guard;
    logic       r, ld;
    logic [3:0] dp, bl;
    repeat (3) cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 16'h12AF, 4'h0, 4'h0);
    repeat (24) cyc(1'b0, 1'b0, rand_val(), 4'hF, 4'hF);
    cyc(1'b0, 1'b1, 16'h3333, 4'h0, 4'h0);
    repeat (40) cyc(1'b0, 1'b0, rand_val(), 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 16'h0050, 4'h0, 4'h0);
    repeat (45) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 16'h0000, 4'h0, 4'h0);
    repeat (45) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 16'h8888, 4'b0100, 4'b0001);
    repeat (45) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    // Reset while dut_a is showing digit 2.
    guard = 0;
    while ((t % 20) != 12 && guard < 40) begin
      cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
      guard++;
    end
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 16'hBEEF, 4'b1000, 4'h0);
    repeat (30) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    repeat (600) begin
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 5) == 0);
      dp = 4'($urandom_range(0, 15));
      bl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      cyc(r, ld, rand_val(), dp, bl);
    end
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
